// File: rtl/cernbe_pkg.sv
// Shared types and constants for the CERN-BE memory target.
// The wait counter is sized for wait counts of 0..15.
package cernbe_pkg;

    localparam int CERNBE_DATA_W = 32;
    localparam int CERNBE_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_WAIT = 2'd1,
        ST_RD_WAIT = 2'd2
    } cernbe_state_e;

endpackage

// File: rtl/cernbe_mem_target_wait_cnt.sv
// Loadable wait-state down-counter shared by the read and write wait states.
// zero_next flags the value the counter will hold after the coming edge.
module cernbe_wait_cnt
    import cernbe_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [CERNBE_CNT_W-1:0] load_val,
    input  logic                    dec,
    output logic                    zero,
    output logic                    zero_next
);

    logic [CERNBE_CNT_W-1:0] cnt_q;
    logic [CERNBE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero      = (cnt_q == '0);
    assign zero_next = (cnt_d == '0);

endmodule

// File: rtl/cernbe_mem_target.sv
// CERN-BE bus responder backed by a resettable flop register file.
// Done pulses and read data are registered, so they are computed one edge early.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for a strobe; a strobe latches address/data
//   ST_WR_WAIT | counting write wait states; at zero the word is written
//   ST_RD_WAIT | counting read wait states; data was loaded on entry to zero
module cernbe_mem_target
    import cernbe_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int RD_WAIT    = 2,
    parameter int WR_WAIT    = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [ADDR_WIDTH+1:2]    VMEAddr,
    input  logic [CERNBE_DATA_W-1:0] VMEWrData,
    input  logic                     VMERdMem,
    input  logic                     VMEWrMem,
    output logic [CERNBE_DATA_W-1:0] VMERdData,
    output logic                     VMERdDone,
    output logic                     VMEWrDone,
    output logic                     Busy,
    output logic                     Overrun
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CERNBE_CNT_W-1:0] RD_CNT = CERNBE_CNT_W'(RD_WAIT);
    localparam logic [CERNBE_CNT_W-1:0] WR_CNT = CERNBE_CNT_W'(WR_WAIT);

    cernbe_state_e           state_q, state_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CERNBE_DATA_W-1:0] wdata_q, wdata_d;
    logic [CERNBE_DATA_W-1:0] rd_data_q, rd_data_d;
    logic                    rd_done_q, rd_done_d;
    logic                    wr_done_q, wr_done_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic [CERNBE_DATA_W-1:0] mem_q [DEPTH];
    logic [CERNBE_DATA_W-1:0] mem_d [DEPTH];

    logic                    strobe;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    cnt_load;
    logic [CERNBE_CNT_W-1:0] cnt_load_val;
    logic                    cnt_dec;
    logic                    cnt_zero;
    logic                    cnt_zero_next;

    cernbe_wait_cnt u_wait_cnt (
        .clk       (Clk),
        .rst       (Rst),
        .load      (cnt_load),
        .load_val  (cnt_load_val),
        .dec       (cnt_dec),
        .zero      (cnt_zero),
        .zero_next (cnt_zero_next)
    );

    assign strobe = VMERdMem | VMEWrMem;

    always_comb begin
        state_d      = state_q;
        rd_pend_d    = rd_pend_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_we       = 1'b0;
        rd_addr      = addr_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    addr_d   = VMEAddr;
                    rd_addr  = VMEAddr;
                    cnt_load = 1'b1;
                    if (VMEWrMem) begin
                        wdata_d      = VMEWrData;
                        rd_pend_d    = VMERdMem;
                        cnt_load_val = WR_CNT;
                        state_d      = ST_WR_WAIT;
                    end else begin
                        cnt_load_val = RD_CNT;
                        state_d      = ST_RD_WAIT;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (cnt_zero) begin
                    mem_we = 1'b1;
                    if (rd_pend_q) begin
                        rd_pend_d    = 1'b0;
                        cnt_load     = 1'b1;
                        cnt_load_val = RD_CNT;
                        state_d      = ST_RD_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pending read with no wait states samples in the same edge as its write,
    // so the written data is forwarded instead of the stale memory word.
    always_comb begin
        wr_done_d = (state_d == ST_WR_WAIT) && cnt_zero_next;
        rd_done_d = (state_d == ST_RD_WAIT) && cnt_zero_next;
        rd_data_d = rd_data_q;
        if (rd_done_d) begin
            rd_data_d = mem_we ? wdata_q : mem_q[rd_addr];
        end
        busy_d    = (state_d != ST_IDLE);
        overrun_d = strobe && (state_q != ST_IDLE);
    end

    always_comb begin
        mem_d = mem_q;
        if (mem_we) begin
            mem_d[addr_q] = wdata_q;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            rd_pend_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            rd_done_q <= rd_done_d;
            wr_done_q <= wr_done_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            mem_q     <= mem_d;
        end
    end

    assign VMERdData = rd_data_q;
    assign VMERdDone = rd_done_q;
    assign VMEWrDone = wr_done_q;
    assign Busy      = busy_q;
    assign Overrun   = overrun_q;

endmodule

// File: tb/tb_cernbe_mem_target.sv
// Directed bench for cernbe_mem_target: per-cycle pulse maps are compared with
// hand-derived patterns (bit k = cycle k after the strobe cycle 0).
module tb_cernbe_mem_target;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [3:0]  VMEAddr;
    logic [31:0] VMEWrData;
    logic        VMERdMem;
    logic        VMEWrMem;
    logic [31:0] VMERdData;
    logic        VMERdDone;
    logic        VMEWrDone;
    logic        Busy;
    logic        Overrun;

    logic [31:0] rd_data3;
    logic        rd_done3;
    logic        wr_done3;
    logic        busy3;
    logic        overrun3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] rd_vec, wr_vec, busy_vec, ovr_vec;
    logic [31:0] last_rd, last_rd3;
    int          inj_cyc = -1;
    logic [31:0] inj_addr, inj_data;

    always #5 Clk = ~Clk;

    cernbe_mem_target #(.ADDR_WIDTH(4), .RD_WAIT(2), .WR_WAIT(1)) dut (
        .Clk(Clk), .Rst(Rst), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
        .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdData(VMERdData),
        .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone), .Busy(Busy), .Overrun(Overrun)
    );

    cernbe_mem_target #(.ADDR_WIDTH(4), .RD_WAIT(2), .WR_WAIT(3)) dut3 (
        .Clk(Clk), .Rst(Rst), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
        .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdData(rd_data3),
        .VMERdDone(rd_done3), .VMEWrDone(wr_done3), .Busy(busy3), .Overrun(overrun3)
    );

    task automatic start(input logic rd, input logic wr, input logic [31:0] byte_addr,
                         input logic [31:0] data);
        VMEAddr   = byte_addr[5:2];
        VMEWrData = data;
        VMERdMem  = rd;
        VMEWrMem  = wr;
    endtask

    // Steps n cycles after the strobe cycle, recording outputs of each cycle.
    task automatic capture(input int n);
        rd_vec      = '0;
        wr_vec      = '0;
        ovr_vec     = '0;
        busy_vec    = '0;
        busy_vec[0] = Busy;
        for (int k = 1; k <= n; k++) begin
            @(posedge Clk);
            #1;
            rd_vec[k]   = VMERdDone;
            wr_vec[k]   = VMEWrDone;
            busy_vec[k] = Busy;
            ovr_vec[k]  = Overrun;
            if (VMERdDone) last_rd = VMERdData;
            if (rd_done3)  last_rd3 = rd_data3;
            VMERdMem = 1'b0;
            VMEWrMem = (k == inj_cyc);
            if (k == inj_cyc) begin
                VMEAddr   = inj_addr[5:2];
                VMEWrData = inj_data;
            end
        end
    endtask

    task automatic apply_reset();
        Rst      = 1'b1;
        VMERdMem = 1'b0;
        VMEWrMem = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        VMERdMem = 1'b0;
        VMEWrMem = 1'b0;
        VMEAddr = '0;
        VMEWrData = '0;
        repeat (2) @(posedge Clk);
        #1;
        total_cnt++;
        if ({VMERdDone, VMEWrDone, Busy, Overrun} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {VMERdDone, VMEWrDone, Busy, Overrun});
        else pass_cnt++;
        total_cnt++;
        if (VMERdData !== 32'h0)
            $display("FAIL reset_rddata: got %h want 00000000", VMERdData);
        else pass_cnt++;
        Rst = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_read_after_reset();
        last_rd = 32'hFFFF_FFFF;
        start(1'b1, 1'b0, 32'h8, 32'h0);
        capture(5);
        total_cnt++;
        if (rd_vec !== 16'b1000) $display("FAIL rd_timing: got %b want %b", rd_vec, 16'b1000);
        else pass_cnt++;
        total_cnt++;
        if (busy_vec !== 16'b1110) $display("FAIL rd_busy: got %b want %b", busy_vec, 16'b1110);
        else pass_cnt++;
        total_cnt++;
        if (last_rd !== 32'h0) $display("FAIL rd_zero_data: got %h want 00000000", last_rd);
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        start(1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF);
        capture(3);
        total_cnt++;
        if (wr_vec !== 16'b0100) $display("FAIL wr_timing: got %b want %b", wr_vec, 16'b0100);
        else pass_cnt++;
        total_cnt++;
        if (busy_vec !== 16'b0110) $display("FAIL wr_busy: got %b want %b", busy_vec, 16'b0110);
        else pass_cnt++;
        last_rd = 32'h0;
        start(1'b1, 1'b0, 32'h4, 32'h0);
        capture(4);
        total_cnt++;
        if (rd_vec !== 16'b1000) $display("FAIL wr_rd_timing: got %b want %b", rd_vec, 16'b1000);
        else pass_cnt++;
        total_cnt++;
        if (last_rd !== 32'hDEAD_BEEF) $display("FAIL wr_rd_data: got %h want deadbeef", last_rd);
        else pass_cnt++;
        total_cnt++;
        if (ovr_vec !== 16'b0) $display("FAIL wr_rd_no_overrun: got %b want 0", ovr_vec);
        else pass_cnt++;
    endtask

    task automatic test_combined();
        last_rd = 32'h0;
        start(1'b1, 1'b1, 32'hC, 32'h1234_5678);
        capture(6);
        total_cnt++;
        if (wr_vec !== 16'b100) $display("FAIL comb_wr_timing: got %b want %b", wr_vec, 16'b100);
        else pass_cnt++;
        total_cnt++;
        if (rd_vec !== 16'b100000) $display("FAIL comb_rd_timing: got %b want %b", rd_vec, 16'b100000);
        else pass_cnt++;
        total_cnt++;
        if (busy_vec !== 16'b111110) $display("FAIL comb_busy: got %b want %b", busy_vec, 16'b111110);
        else pass_cnt++;
        total_cnt++;
        if (last_rd !== 32'h1234_5678) $display("FAIL comb_data: got %h want 12345678", last_rd);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        start(1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5);
        capture(3);
        inj_cyc  = 1;
        inj_addr = 32'h10;
        inj_data = 32'h1111_1111;
        last_rd  = 32'hFFFF_FFFF;
        start(1'b1, 1'b0, 32'h0, 32'h0);
        capture(4);
        inj_cyc = -1;
        total_cnt++;
        if (ovr_vec !== 16'b100) $display("FAIL ovr_pulse: got %b want %b", ovr_vec, 16'b100);
        else pass_cnt++;
        total_cnt++;
        if (rd_vec !== 16'b1000) $display("FAIL ovr_rd_timing: got %b want %b", rd_vec, 16'b1000);
        else pass_cnt++;
        total_cnt++;
        if (wr_vec !== 16'b0) $display("FAIL ovr_no_wrdone: got %b want 0", wr_vec);
        else pass_cnt++;
        last_rd = 32'h0;
        start(1'b1, 1'b0, 32'h10, 32'h0);
        capture(4);
        total_cnt++;
        if (last_rd !== 32'hA5A5_A5A5) $display("FAIL ovr_write_dropped: got %h want a5a5a5a5", last_rd);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        last_rd = 32'h0;
        start(1'b1, 1'b0, 32'h4, 32'h0);
        capture(3);
        total_cnt++;
        if (last_rd !== 32'hDEAD_BEEF) $display("FAIL b2b_first_data: got %h want deadbeef", last_rd);
        else pass_cnt++;
        start(1'b1, 1'b0, 32'hC, 32'h0);
        capture(4);
        total_cnt++;
        if ({ovr_vec[3:0], rd_vec[3:0]} !== 8'b0010_0000)
            $display("FAIL b2b_done_cycle_strobe: got ovr %b rd %b want ovr 0010 rd 0000", ovr_vec[3:0], rd_vec[3:0]);
        else pass_cnt++;
        last_rd = 32'h0;
        start(1'b1, 1'b0, 32'hC, 32'h0);
        capture(3);
        total_cnt++;
        if (rd_vec !== 16'b1000) $display("FAIL b2b_rd_timing: got %b want %b", rd_vec, 16'b1000);
        else pass_cnt++;
        total_cnt++;
        if (last_rd !== 32'h1234_5678) $display("FAIL b2b_data: got %h want 12345678", last_rd);
        else pass_cnt++;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_wrap();
        start(1'b0, 1'b1, 32'h0, 32'h0000_AAAA);
        capture(3);
        start(1'b0, 1'b1, 32'h40, 32'h5555_BBBB);
        capture(3);
        total_cnt++;
        if (wr_vec !== 16'b0100) $display("FAIL wrap_wr_timing: got %b want %b", wr_vec, 16'b0100);
        else pass_cnt++;
        last_rd = 32'h0;
        start(1'b1, 1'b0, 32'h0, 32'h0);
        capture(4);
        total_cnt++;
        if (last_rd !== 32'h5555_BBBB) $display("FAIL wrap_data: got %h want 5555bbbb", last_rd);
        else pass_cnt++;
        last_rd = 32'h0;
        start(1'b1, 1'b0, 32'h44, 32'h0);
        capture(4);
        total_cnt++;
        if (last_rd !== 32'hDEAD_BEEF) $display("FAIL wrap_word1: got %h want deadbeef", last_rd);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic wr_seen;
        apply_reset();
        start(1'b0, 1'b1, 32'h14, 32'hCAFE_F00D);
        @(posedge Clk);
        #1;
        VMEWrMem = 1'b0;
        total_cnt++;
        if ({Busy, busy3} !== 2'b11) $display("FAIL mid_busy_before: got %b want 11", {Busy, busy3});
        else pass_cnt++;
        Rst = 1'b1;
        #1;
        total_cnt++;
        if ({Busy, busy3, VMEWrDone, wr_done3, VMERdDone, rd_done3, Overrun, overrun3} !== 8'b0)
            $display("FAIL mid_async_clear: got %b want 00000000",
                     {Busy, busy3, VMEWrDone, wr_done3, VMERdDone, rd_done3, Overrun, overrun3});
        else pass_cnt++;
        total_cnt++;
        if ({VMERdData, rd_data3} !== 64'h0) $display("FAIL mid_rddata_clear: got %h %h want 0", VMERdData, rd_data3);
        else pass_cnt++;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        wr_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge Clk);
            #1;
            wr_seen = wr_seen | VMEWrDone | wr_done3;
        end
        total_cnt++;
        if (wr_seen !== 1'b0) $display("FAIL mid_no_wrdone: got %b want 0", wr_seen);
        else pass_cnt++;
        last_rd  = 32'hFFFF_FFFF;
        last_rd3 = 32'hFFFF_FFFF;
        start(1'b1, 1'b0, 32'h14, 32'h0);
        capture(4);
        total_cnt++;
        if ({last_rd, last_rd3} !== 64'h0) $display("FAIL mid_word_zero: got %h %h want 0", last_rd, last_rd3);
        else pass_cnt++;
        last_rd = 32'hFFFF_FFFF;
        start(1'b1, 1'b0, 32'h4, 32'h0);
        capture(4);
        total_cnt++;
        if (last_rd !== 32'h0) $display("FAIL mid_mem_cleared: got %h want 00000000", last_rd);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_combined();
        test_overrun();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cernbe_mem_target.md
# cernbe_mem_target

CERN-BE bus responder: terminates a CERN-BE bus initiator port (RdMem/WrMem strobes, RdDone/WrDone acknowledges) on a local register file of 2**ADDR_WIDTH 32-bit words. Read and write wait states are configurable. It sits on the far side of a generated submap port, as a stand-in target for integration and as a scratch/mailbox memory. Overlapping accesses are rejected and flagged.

## Interface
- ADDR_WIDTH, 4: word-address bits; the register file holds 2**ADDR_WIDTH words.
- RD_WAIT, 2: extra read wait cycles, range 0..15.
- WR_WAIT, 1: extra write wait cycles, range 0..15.

- Clk  in  1  single clock; all logic on the rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- VMEAddr  in  [ADDR_WIDTH+1:2]  byte address (word-aligned); sampled with a strobe.
- VMEWrData  in  32  write data; sampled with VMEWrMem.
- VMERdMem  in  1  read strobe, one cycle.
- VMEWrMem  in  1  write strobe, one cycle.
- VMERdData  out  32  read data; valid with VMERdDone and held until the next read completes.
- VMERdDone  out  1  read acknowledge, one-cycle pulse.
- VMEWrDone  out  1  write acknowledge, one-cycle pulse.
- Busy  out  1  an access is in progress.
- Overrun  out  1  one-cycle pulse: a strobe arrived while Busy and was dropped.

## Operation
- FSM states: IDLE, WR_WAIT, RD_WAIT.
- In IDLE, a strobe latches VMEAddr (and VMEWrData for writes) into holding registers.
  - VMEWrMem only: go to WR_WAIT, counter = WR_WAIT.
  - VMERdMem only: go to RD_WAIT, counter = RD_WAIT.
  - Both in the same cycle: go to WR_WAIT and set rd_pend. The write completes first, then the read runs against the same latched address. A read of the written address returns the new data.
- WR_WAIT: when the counter is 0, write the memory word, pulse VMEWrDone, then go to RD_WAIT (if rd_pend, counter = RD_WAIT, clear rd_pend) or to IDLE. Otherwise decrement the counter.
- RD_WAIT: when the counter is 0, load VMERdData from the memory word, pulse VMERdDone, go to IDLE. Otherwise decrement the counter.
- Busy = (state != IDLE), registered. Busy stays high through the cycle carrying the final Done.
- A strobe (either kind) in a cycle with Busy high is ignored: no memory change, no Done. Overrun pulses in the next cycle.
- The address is truncated to ADDR_WIDTH word bits, so out-of-range addresses wrap.
- Reset, at any time including mid-access:
  - state IDLE, rd_pend 0, counters 0;
  - VMERdData = 0; VMERdDone, VMEWrDone, Busy, Overrun = 0;
  - all memory words = 0.
  - An access aborted by reset never produces a Done.

## Timing
- Strobe in cycle 0:
  - write: VMEWrDone in cycle WR_WAIT+1;
  - read: VMERdDone in cycle RD_WAIT+1, with VMERdData valid in that same cycle;
  - combined read+write: VMEWrDone in cycle WR_WAIT+1, VMERdDone in cycle WR_WAIT+RD_WAIT+2.
- Busy is high in cycles 1 through the final Done cycle inclusive. The next strobe is accepted no earlier than the cycle after the final Done. Minimum single-access period is WAIT+2 cycles.
- Memory updates at the clock edge ending the VMEWrDone cycle. A read strobed in the cycle immediately after VMEWrDone sees the new value.
- Every output is registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package cernbe_pkg holds:
  - CERNBE_DATA_W = 32;
  - the FSM state enum type;
  - the wait-counter width constant (4 bits).
- One natural sub-module: cernbe_wait_cnt, a loadable down-counter with a zero flag, instantiated once and shared by both wait states.
- Register file as an array of flops, so that reset can clear it (no BRAM inference).

## Test plan
- Reset then read at 0x8 -> VMERdDone in cycle 3 (RD_WAIT=2), VMERdData = 0x00000000, Busy high in cycles 1-3.
- Write 0xDEADBEEF to 0x4, then read 0x4 starting the cycle after Busy falls -> VMEWrDone in cycle 2, then VMERdData = 0xDEADBEEF with VMERdDone.
- Read and write strobes in the same cycle at 0xC with data 0x12345678 -> VMEWrDone in cycle 2, VMERdDone in cycle 5, VMERdData = 0x12345678.
- Read at 0x0, then a write strobe in cycle 1 -> Overrun pulse in cycle 2, write dropped (a later read of the write address returns its old value), VMERdDone still in cycle 3.
- Write to 0x0 and 0x40 (ADDR_WIDTH=4) -> address wraps; the second write overwrites word 0, and a read of 0x0 returns the second data.
- Assert Rst in cycle 1 of a write with WR_WAIT=3 -> no VMEWrDone, target word unchanged at 0, Busy = 0 immediately, all outputs at reset values.
